entrada_cantidad: RTL and testbench

//   Consumes 4-bit key codes from the keypad encoder latch stage and turns digit

---
 rtl/entrada_cantidad.sv | 183 ++++++++++++++++++
 tb/tb_entrada_cantidad.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/entrada_cantidad.sv
// Keypad quantity entry: turns debounced digit/enter/clear key codes into a
// committed decimal quantity offered to the dispenser with a valid/ack handshake.
module entrada_cantidad #(
  parameter int MAX_DIGITS = 3,
  parameter int MAX_VAL    = 999,
  parameter int CNT_W      = 10,
  parameter int HOLDOFF    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       key_code,
  input  logic             key_avail,
  input  logic             out_ack,
  output logic [CNT_W-1:0] cantidad,
  output logic [1:0]       n_digits,
  output logic [CNT_W-1:0] cantidad_final,
  output logic             out_valid,
  output logic             err
);

  localparam int ACC_W = CNT_W + 4;
  localparam int HO_W  = $clog2(HOLDOFF + 1);
  localparam logic [1:0]      MAX_ND  = 2'(MAX_DIGITS);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF);
  localparam logic [ACC_W-1:0] MAX_ACC = ACC_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, OFFER = 2'd2} state_t;
  typedef enum logic [1:0] {K_DIGIT = 2'd0, K_ENTER = 2'd1, K_CLEAR = 2'd2, K_NONE = 2'd3} key_kind_t;

  function automatic key_kind_t classify(input logic [3:0] code);
    key_kind_t kind;
    case (code)
      4'hA:                      kind = K_ENTER;
      4'hB:                      kind = K_CLEAR;
      4'hC, 4'hD, 4'hE, 4'hF:    kind = K_NONE;
      default:                   kind = K_DIGIT;
    endcase
    return kind;
  endfunction

  state_t           state_r;
  logic             sync1_r;
  logic             sync2_r;
  logic             edge_r;
  logic [HO_W-1:0]  ho_cnt_r;
  logic [ACC_W-1:0] acc_r;

  logic             key_evt_s;
  logic             key_open_s;
  key_kind_t        kind_s;
  logic [ACC_W-1:0] digit_s;
  logic [ACC_W-1:0] mac_s;
  logic             in_range_s;
  logic             room_s;

  // Event detection, key decode and the wide multiply-add used for the next value
  always_comb begin
    key_evt_s  = sync2_r & ~edge_r;
    key_open_s = key_evt_s && (ho_cnt_r == '0);
    kind_s     = classify(key_code);
    digit_s    = {{(ACC_W-4){1'b0}}, key_code};
    mac_s      = (acc_r * ACC_W'(4'd10)) + digit_s;
    in_range_s = (acc_r != '0) && (acc_r <= MAX_ACC);
    room_s     = (n_digits < MAX_ND);
  end

  assign cantidad = acc_r[CNT_W-1:0];

  // Synchroniser, holdoff counter and the entry FSM with all registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r        <= IDLE;
      sync1_r        <= 1'b0;
      sync2_r        <= 1'b0;
      edge_r         <= 1'b0;
      ho_cnt_r       <= '0;
      acc_r          <= '0;
      n_digits       <= 2'd0;
      cantidad_final <= '0;
      out_valid      <= 1'b0;
      err            <= 1'b0;
    end else begin
      sync1_r <= key_avail;
      sync2_r <= sync1_r;
      edge_r  <= sync2_r;
      err     <= 1'b0;

      // A load below takes precedence over this decrement
      if (ho_cnt_r != '0) begin
        ho_cnt_r <= ho_cnt_r - HO_W'(1);
      end else begin
        ho_cnt_r <= ho_cnt_r;
      end

      case (state_r)
        IDLE: begin
          if (key_open_s) begin
            case (kind_s)
              K_DIGIT: begin
                acc_r    <= digit_s;
                n_digits <= 2'd1;
                state_r  <= ENTRY;
                ho_cnt_r <= HO_LOAD;
              end
              K_ENTER: begin
                err      <= 1'b1;
                ho_cnt_r <= HO_LOAD;
              end
              K_CLEAR: begin
                ho_cnt_r <= HO_LOAD;
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end

        ENTRY: begin
          if (key_open_s) begin
            case (kind_s)
              K_DIGIT: begin
                if (room_s) begin
                  acc_r    <= mac_s;
                  n_digits <= n_digits + 2'd1;
                  ho_cnt_r <= HO_LOAD;
                end else begin
                  state_r <= ENTRY;
                end
              end
              K_ENTER: begin
                ho_cnt_r <= HO_LOAD;
                if (in_range_s) begin
                  cantidad_final <= acc_r[CNT_W-1:0];
                  out_valid      <= 1'b1;
                  state_r        <= OFFER;
                end else begin
                  err      <= 1'b1;
                  acc_r    <= '0;
                  n_digits <= 2'd0;
                  state_r  <= IDLE;
                end
              end
              K_CLEAR: begin
                acc_r    <= '0;
                n_digits <= 2'd0;
                state_r  <= IDLE;
                ho_cnt_r <= HO_LOAD;
              end
              default: begin
                state_r <= ENTRY;
              end
            endcase
          end else begin
            state_r <= ENTRY;
          end
        end

        OFFER: begin
          // Key events are dropped here and never load the holdoff
          if (out_ack) begin
            out_valid <= 1'b0;
            acc_r     <= '0;
            n_digits  <= 2'd0;
            state_r   <= IDLE;
          end else begin
            state_r <= OFFER;
          end
        end

        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          acc_r     <= '0;
          n_digits  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entrada_cantidad.sv
// Bench for entrada_cantidad: table of key/ack operations with expected outputs
// queued as each is driven, plus bounce, async reset and MAX_VAL=500 sequences.
module tb_entrada_cantidad;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] key_code, key_code2;
  logic       key_avail, key_avail2, out_ack, out_ack2;
  logic [9:0] cantidad, cantidad_final, cantidad2, cantidad_final2;
  logic [1:0] n_digits, n_digits2;
  logic       out_valid, err, out_valid2, err2;

  int checks = 0;
  int errors = 0;
  int err_cycles = 0;
  int err2_cycles = 0;
  int valid2_cycles = 0;
  logic err_prev = 1'b0;
  logic valid_prev = 1'b0;

  always #5 CLK = ~CLK;

  entrada_cantidad dut (
    .CLK(CLK), .RST_N(RST_N), .key_code(key_code), .key_avail(key_avail),
    .out_ack(out_ack), .cantidad(cantidad), .n_digits(n_digits),
    .cantidad_final(cantidad_final), .out_valid(out_valid), .err(err)
  );

  entrada_cantidad #(.MAX_VAL(500)) dut500 (
    .CLK(CLK), .RST_N(RST_N), .key_code(key_code2), .key_avail(key_avail2),
    .out_ack(out_ack2), .cantidad(cantidad2), .n_digits(n_digits2),
    .cantidad_final(cantidad_final2), .out_valid(out_valid2), .err(err2)
  );

  typedef enum {OP_KEY, OP_ACK} op_t;
  typedef struct {
    op_t        op;
    logic [3:0] code;
    int         exp_cant;
    int         exp_nd;
    int         exp_valid;
    int         exp_final;
    int         exp_err;
  } vec_t;

  vec_t vecs[24];
  vec_t exp_q[$];

  function automatic vec_t v(op_t op, logic [3:0] code, int cant, int nd,
                             int valid, int fin, int e);
    vec_t r;
    r.op = op; r.code = code; r.exp_cant = cant; r.exp_nd = nd;
    r.exp_valid = valid; r.exp_final = fin; r.exp_err = e;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // err must be a single-cycle pulse and never coincide with out_valid rising
  always @(negedge CLK) begin
    if (err) begin
      err_cycles++;
      checks++;
      if (err_prev || (out_valid && !valid_prev)) begin
        errors++;
        $display("FAIL err_shape: err_prev=%0b valid_rise=%0b expected 0 0",
                 err_prev, out_valid && !valid_prev);
      end
    end
    if (err2) err2_cycles++;
    if (out_valid2) valid2_cycles++;
    err_prev   = err;
    valid_prev = out_valid;
  end

  // Caller is at #1 after a rising edge
  task automatic press(input int which, input logic [3:0] code);
    if (which == 0) begin key_code = code; key_avail = 1'b1; end
    else begin key_code2 = code; key_avail2 = 1'b1; end
    repeat (8) @(posedge CLK);
    #1;
    if (which == 0) key_avail = 1'b0; else key_avail2 = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
  endtask

  task automatic ack_pulse();
    out_ack = 1'b1;
    @(posedge CLK);
    #1;
    out_ack = 1'b0;
  endtask

  task automatic run_row(input int idx, input vec_t r);
    vec_t got;
    int   e0;
    e0 = err_cycles;
    exp_q.push_back(r);
    if (r.op == OP_KEY) press(0, r.code);
    else ack_pulse();
    got = exp_q.pop_front();
    check($sformatf("row%0d_cantidad", idx), int'(cantidad), got.exp_cant);
    check($sformatf("row%0d_n_digits", idx), int'(n_digits), got.exp_nd);
    check($sformatf("row%0d_out_valid", idx), int'(out_valid), got.exp_valid);
    if (got.exp_valid != 0)
      check($sformatf("row%0d_cantidad_final", idx), int'(cantidad_final), got.exp_final);
    check($sformatf("row%0d_err_pulses", idx), err_cycles - e0, got.exp_err);
    if (r.op == OP_ACK) begin
      repeat (2) @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int e0;
    vecs[0]  = v(OP_KEY, 4'h1,   1, 1, 0,   0, 0);
    vecs[1]  = v(OP_KEY, 4'h2,  12, 2, 0,   0, 0);
    vecs[2]  = v(OP_KEY, 4'h5, 125, 3, 0,   0, 0);
    vecs[3]  = v(OP_KEY, 4'hA, 125, 3, 1, 125, 0);
    vecs[4]  = v(OP_KEY, 4'h7, 125, 3, 1, 125, 0);
    vecs[5]  = v(OP_ACK, 4'h0,   0, 0, 0,   0, 0);
    vecs[6]  = v(OP_KEY, 4'h9,   9, 1, 0,   0, 0);
    vecs[7]  = v(OP_KEY, 4'h9,  99, 2, 0,   0, 0);
    vecs[8]  = v(OP_KEY, 4'h9, 999, 3, 0,   0, 0);
    vecs[9]  = v(OP_KEY, 4'h9, 999, 3, 0,   0, 0);
    vecs[10] = v(OP_KEY, 4'hA, 999, 3, 1, 999, 0);
    vecs[11] = v(OP_ACK, 4'h0,   0, 0, 0,   0, 0);
    vecs[12] = v(OP_KEY, 4'h0,   0, 1, 0,   0, 0);
    vecs[13] = v(OP_KEY, 4'h5,   5, 2, 0,   0, 0);
    vecs[14] = v(OP_KEY, 4'hA,   5, 2, 1,   5, 0);
    vecs[15] = v(OP_ACK, 4'h0,   0, 0, 0,   0, 0);
    vecs[16] = v(OP_KEY, 4'h0,   0, 1, 0,   0, 0);
    vecs[17] = v(OP_KEY, 4'hA,   0, 0, 0,   0, 1);
    vecs[18] = v(OP_KEY, 4'h4,   4, 1, 0,   0, 0);
    vecs[19] = v(OP_ACK, 4'h0,   4, 1, 0,   0, 0);
    vecs[20] = v(OP_KEY, 4'hC,   4, 1, 0,   0, 0);
    vecs[21] = v(OP_KEY, 4'hB,   0, 0, 0,   0, 0);
    vecs[22] = v(OP_KEY, 4'hA,   0, 0, 0,   0, 1);
    vecs[23] = v(OP_KEY, 4'hB,   0, 0, 0,   0, 0);

    RST_N = 1'b0;
    key_code = 4'h0; key_code2 = 4'h0;
    key_avail = 1'b0; key_avail2 = 1'b0;
    out_ack = 1'b0; out_ack2 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_cantidad", int'(cantidad), 0);
    check("reset_n_digits", int'(n_digits), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_final", int'(cantidad_final), 0);
    check("reset_err", int'(err), 0);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    for (int i = 0; i < 24; i++) run_row(i, vecs[i]);

    // Bounce: three rising edges well inside the holdoff window
    key_code = 4'h3;
    for (int b = 0; b < 2; b++) begin
      key_avail = 1'b1; repeat (2) @(posedge CLK); #1;
      key_avail = 1'b0; repeat (2) @(posedge CLK); #1;
    end
    key_avail = 1'b1; repeat (8) @(posedge CLK); #1;
    key_avail = 1'b0; repeat (20) @(posedge CLK); #1;
    check("bounce_cantidad", int'(cantidad), 3);
    check("bounce_n_digits", int'(n_digits), 1);
    press(0, 4'h7);
    check("pre_reset_cantidad", int'(cantidad), 37);

    // Asynchronous reset mid-entry, sampled before any further clock edge
    RST_N = 1'b0;
    #1;
    check("async_rst_cantidad", int'(cantidad), 0);
    check("async_rst_n_digits", int'(n_digits), 0);
    check("async_rst_final", int'(cantidad_final), 0);
    check("async_rst_valid", int'(out_valid), 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    e0 = err_cycles;
    press(0, 4'hA);
    check("post_rst_enter_err", err_cycles - e0, 1);
    check("post_rst_cantidad", int'(cantidad), 0);

    // MAX_VAL=500 instance: 600 is rejected on enter
    press(1, 4'h6);
    press(1, 4'h0);
    press(1, 4'h0);
    check("mv500_cantidad", int'(cantidad2), 600);
    check("mv500_n_digits", int'(n_digits2), 3);
    e0 = err2_cycles;
    press(1, 4'hA);
    check("mv500_err_pulses", err2_cycles - e0, 1);
    check("mv500_cantidad_after", int'(cantidad2), 0);
    check("mv500_n_digits_after", int'(n_digits2), 0);
    check("mv500_valid_cycles", valid2_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
